// File: rtl/pcs_receive_pkg.sv
// Shared constants and types for the 1000BASE-X PCS receive path:
// special code-group encodings (both running-disparity columns), their
// decoded octets, the receive state set and the pipeline stage record.
package pcs_receive_pkg;

    // Special code-groups, {a,b,c,d,e,i,f,g,h,j} with a at bit 9
    localparam logic [9:0] K28_5_N = 10'b0011111010;
    localparam logic [9:0] K28_5_P = 10'b1100000101;
    localparam logic [9:0] K27_7_N = 10'b1101101000;
    localparam logic [9:0] K27_7_P = 10'b0010010111;
    localparam logic [9:0] K29_7_N = 10'b1011101000;
    localparam logic [9:0] K29_7_P = 10'b0100010111;
    localparam logic [9:0] K23_7_N = 10'b1110101000;
    localparam logic [9:0] K23_7_P = 10'b0001010111;

    // Decoded octet values of the recognised K groups
    localparam logic [7:0] K28_5_OCTET = 8'hBC;  // comma
    localparam logic [7:0] K27_7_OCTET = 8'hFB;  // /S/
    localparam logic [7:0] K29_7_OCTET = 8'hFD;  // /T/
    localparam logic [7:0] K23_7_OCTET = 8'hF7;  // /R/

    typedef enum logic [2:0] {
        ST_LINK_FAILED,
        ST_WAIT_FOR_K,
        ST_RX_K,
        ST_IDLE_D,
        ST_RECEIVE,
        ST_TRR
    } rx_state_e;

    typedef struct packed {
        logic [7:0] octet;
        logic       is_k;
        logic       valid;
        logic       rx_even;
    } stage_t;

    // True when the stage holds the given special code-group
    function automatic logic is_k_group(stage_t s, logic [7:0] code);
        return s.valid && s.is_k && (s.octet == code);
    endfunction

    // True for data code-groups only
    function automatic logic is_data(stage_t s);
        return s.valid && !s.is_k;
    endfunction

endpackage

// File: rtl/pcs_receive_code_group_decoder.sv
// Combinational 10b -> 8b code-group decoder. Both running-disparity
// columns are accepted and disparity is not checked. The four special
// groups are matched first, so K27.7/K29.7/K23.7 never alias onto the
// lenient D.x.A7 decode.
module pcs_receive_code_group_decoder
    import pcs_receive_pkg::*;
(
    input  logic [9:0] code_group,
    output logic [7:0] octet,
    output logic       is_k,
    output logic       valid
);

    logic [5:0] six_b;
    logic [3:0] four_b;
    logic [4:0] edcba;
    logic [2:0] hgf;
    logic       six_ok;
    logic       four_ok;

    assign six_b  = code_group[9:4];
    assign four_b = code_group[3:0];

    // 6b -> 5b lookup over both disparity columns
    always_comb begin
        edcba  = '0;
        six_ok = 1'b1;
        case (six_b)
            6'b100111, 6'b011000: edcba = 5'd0;
            6'b011101, 6'b100010: edcba = 5'd1;
            6'b101101, 6'b010010: edcba = 5'd2;
            6'b110001:            edcba = 5'd3;
            6'b110101, 6'b001010: edcba = 5'd4;
            6'b101001:            edcba = 5'd5;
            6'b011001:            edcba = 5'd6;
            6'b111000, 6'b000111: edcba = 5'd7;
            6'b111001, 6'b000110: edcba = 5'd8;
            6'b100101:            edcba = 5'd9;
            6'b010101:            edcba = 5'd10;
            6'b110100:            edcba = 5'd11;
            6'b001101:            edcba = 5'd12;
            6'b101100:            edcba = 5'd13;
            6'b011100:            edcba = 5'd14;
            6'b010111, 6'b101000: edcba = 5'd15;
            6'b011011, 6'b100100: edcba = 5'd16;
            6'b100011:            edcba = 5'd17;
            6'b010011:            edcba = 5'd18;
            6'b110010:            edcba = 5'd19;
            6'b001011:            edcba = 5'd20;
            6'b101010:            edcba = 5'd21;
            6'b011010:            edcba = 5'd22;
            6'b111010, 6'b000101: edcba = 5'd23;
            6'b110011, 6'b001100: edcba = 5'd24;
            6'b100110:            edcba = 5'd25;
            6'b010110:            edcba = 5'd26;
            6'b110110, 6'b001001: edcba = 5'd27;
            6'b001110:            edcba = 5'd28;
            6'b101110, 6'b010001: edcba = 5'd29;
            6'b011110, 6'b100001: edcba = 5'd30;
            6'b101011, 6'b010100: edcba = 5'd31;
            default:              six_ok = 1'b0;
        endcase
    end

    // 4b -> 3b lookup; x.7 accepts both primary and alternate forms
    always_comb begin
        hgf     = '0;
        four_ok = 1'b1;
        case (four_b)
            4'b1011, 4'b0100:                   hgf = 3'd0;
            4'b1001:                            hgf = 3'd1;
            4'b0101:                            hgf = 3'd2;
            4'b1100, 4'b0011:                   hgf = 3'd3;
            4'b1101, 4'b0010:                   hgf = 3'd4;
            4'b1010:                            hgf = 3'd5;
            4'b0110:                            hgf = 3'd6;
            4'b1110, 4'b0001, 4'b0111, 4'b1000: hgf = 3'd7;
            default:                            four_ok = 1'b0;
        endcase
    end

    // Special groups override the data decode
    always_comb begin
        is_k  = 1'b1;
        octet = {hgf, edcba};
        case (code_group)
            K28_5_N, K28_5_P: octet = K28_5_OCTET;
            K27_7_N, K27_7_P: octet = K27_7_OCTET;
            K29_7_N, K29_7_P: octet = K29_7_OCTET;
            K23_7_N, K23_7_P: octet = K23_7_OCTET;
            default:          is_k  = 1'b0;
        endcase
        valid = is_k || (six_ok && four_ok);
    end

endmodule

// File: rtl/pcs_receive.sv
// 1000BASE-X PCS receive: decodes SUDI code-groups through a two-stage
// pipeline and drives GMII RXD/RX_DV/RX_ER plus the receiving indication.
// The state machine acts on stage 1 with stage 0 as a one-group lookahead
// (needed to qualify /T/ by a following /R/); all outputs are registered,
// giving two cycles from a SUDI sample to RXD.
module pcs_receive
    import pcs_receive_pkg::*;
#(
    parameter logic [7:0] SOP_RXD = 8'h55,
    parameter logic [7:0] ERR_RXD = 8'h00
) (
    input  logic        Clk,
    input  logic        mr_main_reset,
    input  logic        code_sync_status,
    input  logic [10:0] SUDI,
    output logic [7:0]  RXD,
    output logic        RX_DV,
    output logic        RX_ER,
    output logic        receiving
);

    logic [7:0] dec_octet;
    logic       dec_is_k;
    logic       dec_valid;

    pcs_receive_code_group_decoder u_decoder (
        .code_group (SUDI[9:0]),
        .octet      (dec_octet),
        .is_k       (dec_is_k),
        .valid      (dec_valid)
    );

    rx_state_e  state_q, state_d;
    stage_t     stg0_q, stg0_d;
    stage_t     stg1_q, stg1_d;
    logic [7:0] rxd_q, rxd_d;
    logic       rx_dv_q, rx_dv_d;
    logic       rx_er_q, rx_er_d;
    logic       receiving_q, receiving_d;

    logic       comma_even;
    logic       sop;
    logic       eop_qualified;

    assign comma_even    = is_k_group(stg1_q, K28_5_OCTET) && stg1_q.rx_even;
    assign sop           = is_k_group(stg1_q, K27_7_OCTET);
    assign eop_qualified = is_k_group(stg1_q, K29_7_OCTET) && is_k_group(stg0_q, K23_7_OCTET);

    // Next-state, pipeline advance and next output values
    always_comb begin
        stg0_d      = '{octet: dec_octet, is_k: dec_is_k, valid: dec_valid, rx_even: SUDI[10]};
        stg1_d      = stg0_q;
        state_d     = state_q;
        rxd_d       = '0;
        rx_dv_d     = 1'b0;
        rx_er_d     = 1'b0;
        receiving_d = 1'b0;

        if (!code_sync_status) begin
            // Loss of sync beats any in-state decision; a frame in flight
            // is closed with a single RX_ER cycle.
            state_d = ST_LINK_FAILED;
            rx_er_d = rx_dv_q;
        end else begin
            case (state_q)
                ST_LINK_FAILED: state_d = ST_WAIT_FOR_K;

                ST_WAIT_FOR_K: begin
                    if (comma_even) state_d = ST_RX_K;
                end

                ST_RX_K: state_d = is_data(stg1_q) ? ST_IDLE_D : ST_WAIT_FOR_K;

                ST_IDLE_D: begin
                    if (comma_even) begin
                        state_d = ST_RX_K;
                    end else if (sop) begin
                        state_d     = ST_RECEIVE;
                        rxd_d       = SOP_RXD;
                        rx_dv_d     = 1'b1;
                        receiving_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT_FOR_K;
                    end
                end

                ST_RECEIVE: begin
                    // receiving stays high through the /T/ or early-end cycle
                    receiving_d = 1'b1;
                    if (is_data(stg1_q)) begin
                        rxd_d   = stg1_q.octet;
                        rx_dv_d = 1'b1;
                    end else if (eop_qualified) begin
                        state_d = ST_TRR;
                    end else if (comma_even) begin
                        state_d = ST_RX_K;
                        rx_er_d = 1'b1;
                    end else begin
                        // Invalid group, stray K, or /T/ not followed by /R/
                        rxd_d   = ERR_RXD;
                        rx_dv_d = 1'b1;
                        rx_er_d = 1'b1;
                    end
                end

                ST_TRR: begin
                    if (comma_even) begin
                        state_d = ST_RX_K;
                    end else if (!stg1_q.valid) begin
                        state_d = ST_WAIT_FOR_K;
                    end
                end

                default: state_d = ST_LINK_FAILED;
            endcase
        end
    end

    // State, pipeline and output registers with asynchronous clear
    always_ff @(posedge Clk or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            state_q     <= ST_LINK_FAILED;
            stg0_q      <= '0;
            stg1_q      <= '0;
            rxd_q       <= '0;
            rx_dv_q     <= 1'b0;
            rx_er_q     <= 1'b0;
            receiving_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stg0_q      <= stg0_d;
            stg1_q      <= stg1_d;
            rxd_q       <= rxd_d;
            rx_dv_q     <= rx_dv_d;
            rx_er_q     <= rx_er_d;
            receiving_q <= receiving_d;
        end
    end

    assign RXD       = rxd_q;
    assign RX_DV     = rx_dv_q;
    assign RX_ER     = rx_er_q;
    assign receiving = receiving_q;

endmodule

// File: tb/tb_pcs_receive.sv
// Bench for pcs_receive. Stimulus is a directed list of abstract symbols
// (data octet, comma, /S/, /T/, /R/, bad group) with per-symbol rx_even and
// sync. A symbol-level model turns that list into the expected GMII output
// for every cycle; a few hand-computed values pin the model.
module tb_pcs_receive;

    localparam logic [7:0] SOP = 8'h55;
    localparam logic [7:0] ERR = 8'hEE;

    typedef enum int { TK_D, TK_I, TK_S, TK_T, TK_R, TK_BAD } tok_e;
    typedef struct {
        tok_e       kind;
        logic [7:0] data;
        bit         even;
        bit         sync;
        bit         col;
    } tok_t;

    typedef enum int { L_DOWN, L_HUNT, L_COMMA, L_IDLE, L_FRAME, L_TAIL } link_e;

    // RD- column of the 5b/6b and 3b/4b tables (index = EDCBA / HGF)
    localparam logic [5:0] D6 [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011
    };
    localparam logic [3:0] D4 [8] = '{
        4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110
    };

    logic        Clk = 1'b0;
    logic        mr_main_reset;
    logic        code_sync_status;
    logic [10:0] SUDI;
    logic [7:0]  RXD;
    logic        RX_DV;
    logic        RX_ER;
    logic        receiving;

    pcs_receive #(
        .SOP_RXD (SOP),
        .ERR_RXD (ERR)
    ) dut (
        .Clk              (Clk),
        .mr_main_reset    (mr_main_reset),
        .code_sync_status (code_sync_status),
        .SUDI             (SUDI),
        .RXD              (RXD),
        .RX_DV            (RX_DV),
        .RX_ER            (RX_ER),
        .receiving        (receiving)
    );

    always #5 Clk = ~Clk;

    tok_t        stim[$];
    logic [10:0] exp_q[$];   // {RXD, RX_DV, RX_ER, receiving}
    bit          next_even = 1'b1;
    bit          cur_sync  = 1'b0;
    int unsigned col_ctr   = 0;
    int          n_vec     = 0;
    int          n_bad     = 0;

    task automatic push(tok_e k, logic [7:0] d);
        tok_t t;
        t.kind = k;
        t.data = d;
        t.even = next_even;
        t.sync = cur_sync;
        t.col  = col_ctr[0] ^ col_ctr[2];
        col_ctr++;
        stim.push_back(t);
        next_even = !next_even;
    endtask

    task automatic idles(int n);
        for (int i = 0; i < n; i++) begin
            push(TK_I, 8'h00);
            push(TK_D, 8'h50);   // D16.2
        end
    endtask

    task automatic end_frame();
        push(TK_T, 8'h00);
        push(TK_R, 8'h00);
        while (!next_even) push(TK_R, 8'h00);
    endtask

    function automatic logic [9:0] enc(tok_t t);
        logic [5:0]  s6;
        logic [3:0]  s4;
        int unsigned x;
        int unsigned y;
        case (t.kind)
            TK_I:   return t.col ? 10'b1100000101 : 10'b0011111010;
            TK_S:   return t.col ? 10'b0010010111 : 10'b1101101000;
            TK_T:   return t.col ? 10'b0100010111 : 10'b1011101000;
            TK_R:   return t.col ? 10'b0001010111 : 10'b1110101000;
            TK_BAD: return 10'b1111111111;
            default: begin
                x  = t.data[4:0];
                y  = t.data[7:5];
                s6 = D6[x];
                if (t.col && ($countones(s6) != 3 || x == 7)) s6 = ~s6;
                s4 = D4[y];
                if (t.col && ($countones(s4) != 2 || y == 3)) s4 = ~s4;
                if (y == 7 && ((!t.col && (x == 17 || x == 18 || x == 20)) ||
                               ( t.col && (x == 11 || x == 13 || x == 14))))
                    s4 = t.col ? 4'b1000 : 4'b0111;
                return {s6, s4};
            end
        endcase
    endfunction

    // Symbol-level reference: the output after edge k reflects symbol k-2,
    // with symbol k-1 as lookahead and sync as presented at edge k.
    task automatic build_expected();
        link_e       mode;
        bit          prev_dv;
        tok_t        cur;
        tok_t        nxt;
        logic [10:0] o;
        bit          comma;
        mode    = L_DOWN;
        prev_dv = 1'b0;
        for (int k = 0; k < stim.size(); k++) begin
            cur.kind = TK_BAD; cur.data = 8'h00; cur.even = 1'b0; cur.sync = 1'b1; cur.col = 1'b0;
            nxt = cur;
            if (k >= 2) cur = stim[k-2];
            if (k >= 1) nxt = stim[k-1];
            comma = (cur.kind == TK_I) && cur.even;
            o = '0;
            if (!stim[k].sync) begin
                if (prev_dv) o = {8'h00, 1'b0, 1'b1, 1'b0};
                mode = L_DOWN;
            end else begin
                case (mode)
                    L_DOWN:  mode = L_HUNT;
                    L_HUNT:  if (comma) mode = L_COMMA;
                    L_COMMA: mode = (cur.kind == TK_D) ? L_IDLE : L_HUNT;
                    L_IDLE: begin
                        if (comma) mode = L_COMMA;
                        else if (cur.kind == TK_S) begin
                            o    = {SOP, 1'b1, 1'b0, 1'b1};
                            mode = L_FRAME;
                        end else mode = L_HUNT;
                    end
                    L_FRAME: begin
                        if (cur.kind == TK_D) o = {cur.data, 1'b1, 1'b0, 1'b1};
                        else if (cur.kind == TK_T && nxt.kind == TK_R) begin
                            o    = {8'h00, 1'b0, 1'b0, 1'b1};
                            mode = L_TAIL;
                        end else if (comma) begin
                            o    = {8'h00, 1'b0, 1'b1, 1'b1};
                            mode = L_COMMA;
                        end else o = {ERR, 1'b1, 1'b1, 1'b1};
                    end
                    default: begin
                        if (comma) mode = L_COMMA;
                        else if (cur.kind == TK_BAD) mode = L_HUNT;
                    end
                endcase
            end
            exp_q.push_back(o);
            prev_dv = o[2];
        end
    endtask

    task automatic check(string name, logic [10:0] got, logic [10:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got rxd=%02h dv=%b er=%b recv=%b, want rxd=%02h dv=%b er=%b recv=%b",
                     name, got[10:3], got[2], got[1], got[0], want[10:3], want[2], want[1], want[0]);
        end
    endtask

    int s_t3, s_t4, s_t5, s_x, j_t6;

    initial begin
        logic [7:0] t3_bytes [11];
        t3_bytes = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5, 8'h01, 8'h02, 8'h03};

        // T1: sync low after reset
        cur_sync = 1'b0;
        idles(3);
        // T2: idle stream
        cur_sync = 1'b1;
        idles(4);
        // T3: preamble frame
        s_t3 = stim.size();
        push(TK_S, 8'h00);
        foreach (t3_bytes[i]) push(TK_D, t3_bytes[i]);
        end_frame();
        idles(3);
        // T4: invalid group mid-frame
        s_t4 = stim.size();
        push(TK_S, 8'h00);
        push(TK_D, 8'h10); push(TK_D, 8'h20); push(TK_BAD, 8'h00); push(TK_D, 8'h30); push(TK_D, 8'h40);
        end_frame();
        idles(3);
        // T5: early end on an even comma
        s_t5 = stim.size();
        push(TK_S, 8'h00);
        push(TK_D, 8'hA1); push(TK_D, 8'hA2); push(TK_D, 8'hA3);
        idles(4);
        // Every octet value, both disparity columns mixed; ends on /T/R/R/
        s_x = stim.size();
        push(TK_S, 8'h00);
        for (int b = 0; b < 256; b++) push(TK_D, 8'(b));
        end_frame();
        idles(3);
        // T6: sync loss mid-frame, then recovery and a short frame
        push(TK_S, 8'h00);
        push(TK_D, 8'h11); push(TK_D, 8'h22); push(TK_D, 8'h33); push(TK_D, 8'h44); push(TK_D, 8'h66);
        cur_sync = 1'b0;
        j_t6 = stim.size();
        idles(3);
        cur_sync = 1'b1;
        idles(3);
        push(TK_S, 8'h00);
        push(TK_D, 8'hAB); push(TK_D, 8'hCD);
        end_frame();
        idles(2);
        // Frame left open for the asynchronous reset check
        push(TK_S, 8'h00);
        push(TK_D, 8'h77); push(TK_D, 8'h88); push(TK_D, 8'h99); push(TK_D, 8'h9A); push(TK_D, 8'h9B);

        build_expected();

        // Model pins, worked out by hand from the symbol positions
        check("pin_t3_sop",   exp_q[s_t3 + 2],  {8'h55, 1'b1, 1'b0, 1'b1});
        check("pin_t3_sfd",   exp_q[s_t3 + 10], {8'hD5, 1'b1, 1'b0, 1'b1});
        check("pin_t3_last",  exp_q[s_t3 + 13], {8'h03, 1'b1, 1'b0, 1'b1});
        check("pin_t3_term",  exp_q[s_t3 + 14], {8'h00, 1'b0, 1'b0, 1'b1});
        check("pin_t3_trr",   exp_q[s_t3 + 15], 11'h000);
        check("pin_t4_err",   exp_q[s_t4 + 5],  {8'hEE, 1'b1, 1'b1, 1'b1});
        check("pin_t4_cont",  exp_q[s_t4 + 6],  {8'h30, 1'b1, 1'b0, 1'b1});
        check("pin_t5_early", exp_q[s_t5 + 6],  {8'h00, 1'b0, 1'b1, 1'b1});
        check("pin_t5_after", exp_q[s_t5 + 7],  11'h000);
        check("pin_x_bc",     exp_q[s_x + 3 + 8'hBC], {8'hBC, 1'b1, 1'b0, 1'b1});
        check("pin_t6_pulse", exp_q[j_t6],      {8'h00, 1'b0, 1'b1, 1'b0});
        check("pin_t6_quiet", exp_q[j_t6 + 1],  11'h000);

        // Reset held with sync low
        mr_main_reset    = 1'b0;
        code_sync_status = 1'b0;
        SUDI             = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            check("reset_hold", {RXD, RX_DV, RX_ER, receiving}, 11'h000);
        end
        mr_main_reset = 1'b1;

        // Per-cycle comparison against the model
        for (int k = 0; k < stim.size(); k++) begin
            SUDI             = {stim[k].even, enc(stim[k])};
            code_sync_status = stim[k].sync;
            @(posedge Clk); #1;
            check($sformatf("cycle%0d", k), {RXD, RX_DV, RX_ER, receiving}, exp_q[k]);
        end

        // Asynchronous reset mid-frame: immediate clear, no RX_ER pulse
        mr_main_reset = 1'b0;
        #1;
        check("async_reset_now", {RXD, RX_DV, RX_ER, receiving}, 11'h000);
        for (int i = 0; i < 2; i++) begin
            @(posedge Clk); #1;
            check("async_reset_held", {RXD, RX_DV, RX_ER, receiving}, 11'h000);
        end
        code_sync_status = 1'b0;
        mr_main_reset    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge Clk); #1;
            check("after_reset", {RXD, RX_DV, RX_ER, receiving}, 11'h000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
